// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status-class constants, message-length decode and
// the message FSM state type used by midi_msg_tx.
package midi_pkg;

  // Channel-voice status classes (low nibble is the channel).
  localparam logic [7:0] NOTE_OFF         = 8'h80;
  localparam logic [7:0] NOTE_ON          = 8'h90;
  localparam logic [7:0] POLY_PRESSURE    = 8'hA0;
  localparam logic [7:0] CONTROL_CHANGE   = 8'hB0;
  localparam logic [7:0] PROGRAM_CHANGE   = 8'hC0;
  localparam logic [7:0] CHANNEL_PRESSURE = 8'hD0;
  localparam logic [7:0] PITCH_BEND       = 8'hE0;

  // System common / realtime.
  localparam logic [7:0] SYSEX            = 8'hF0;
  localparam logic [7:0] MTC_QUARTER      = 8'hF1;
  localparam logic [7:0] SONG_POSITION    = 8'hF2;
  localparam logic [7:0] SONG_SELECT      = 8'hF3;
  localparam logic [7:0] TIMING_CLOCK     = 8'hF8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend
  } state_e;

  // Total bytes in a message (status included); 0 for a non-status byte.
  function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    if (status[7]) begin
      case ({status[7:4], 4'h0})
        NOTE_OFF, NOTE_ON, POLY_PRESSURE, CONTROL_CHANGE, PITCH_BEND: len = 2'd3;
        PROGRAM_CHANGE, CHANNEL_PRESSURE:                            len = 2'd2;
        default: begin
          if (status == SONG_POSITION) begin
            len = 2'd3;
          end else if (status == MTC_QUARTER || status == SONG_SELECT) begin
            len = 2'd2;
          end else begin
            len = 2'd1;
          end
        end
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_msg_tx_if.sv
// Message handshake bundle for midi_msg_tx.
//   msg_valid  : message present on msg_* (master -> slave)
//   msg_ready  : slave can accept this cycle (slave -> master)
//   msg_status : status byte, bit7 set for a real status
//   msg_data1/2: data bytes, sent with bit7 = 0
interface midi_msg_tx_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;

  modport master (
    output msg_valid,
    output msg_status,
    output msg_data1,
    output msg_data2,
    input  msg_ready
  );

  modport slave (
    input  msg_valid,
    input  msg_status,
    input  msg_data1,
    input  msg_data2,
    output msg_ready
  );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A start pulse loads a byte; the start bit appears on
// tx the following cycle. done is high during the last cycle of the stop bit,
// and start may be asserted in that same cycle to chain bytes with no gap.
//   clk, reset : clock, synchronous active-high reset
//   start      : load data and begin a frame (only when idle or on done)
//   data       : byte to send, LSB first
//   tx         : serial line, idle high
//   done       : last cycle of the stop bit
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);

  logic              active_q;
  logic [TimerW-1:0] timer_q;
  logic [3:0]        bit_q;    // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]        shift_q;  // remaining data bits with the stop bit on top
  logic              tx_q;
  logic              bit_end;

  assign bit_end = active_q && (timer_q == TimerMax);
  assign done    = bit_end && (bit_q == 4'd9);
  assign tx      = tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      tx_q     <= 1'b1;
    end else if (start) begin
      active_q <= 1'b1;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= {1'b1, data};
      tx_q     <= 1'b0;
    end else if (bit_end) begin
      timer_q <= '0;
      if (bit_q == 4'd9) begin
        active_q <= 1'b0;
        bit_q    <= '0;
        tx_q     <= 1'b1;
      end else begin
        bit_q   <= bit_q + 4'd1;
        tx_q    <= shift_q[0];
        shift_q <= {1'b1, shift_q[8:1]};
      end
    end else if (active_q) begin
      timer_q <= timer_q + TimerW'(1);
    end
  end

endmodule

// File: rtl/midi_msg_tx.sv
// MIDI message transmitter: accepts one message per handshake, works out its
// byte count from the status, drops a repeated channel status when running
// status is enabled, and streams the bytes as back-to-back 8N1 frames.
//   clk, reset : clock, synchronous active-high reset
//   msg        : slave side of the message handshake
//   serial_tx  : MIDI line, idle high
//   busy       : high from acceptance until the last stop bit completes
module midi_msg_tx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 16000000,
  parameter int unsigned BAUD           = 31250,
  parameter int unsigned RUNNING_STATUS = 1
) (
  input  logic               clk,
  input  logic               reset,
  midi_msg_tx_if.slave       msg,
  output logic               serial_tx,
  output logic               busy
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;

  state_e     state_q, state_d;
  logic [1:0] byte_idx_q, byte_idx_d;  // 0 = status, 1 = data1, 2 = data2
  logic [1:0] last_idx_q, last_idx_d;
  logic [7:0] status_q;
  logic [6:0] data1_q, data2_q;
  logic [7:0] rs_q;
  logic       rs_valid_q;

  logic       ready;
  logic       accept;
  logic [1:0] in_len;
  logic       in_channel;
  logic       in_omit;
  logic       uart_start;
  logic [7:0] uart_data;
  logic       uart_done;

  function automatic logic [7:0] pick_byte(input logic [1:0] idx, input logic [7:0] st,
                                           input logic [6:0] d1, input logic [6:0] d2);
    case (idx)
      2'd0:    return st;
      2'd1:    return {1'b0, d1};
      default: return {1'b0, d2};
    endcase
  endfunction

  assign ready         = (state_q == StIdle);
  assign msg.msg_ready = ready;
  assign accept        = msg.msg_valid && ready;
  assign busy          = !ready;

  assign in_len     = midi_msg_len(msg.msg_status);
  assign in_channel = (msg.msg_status >= NOTE_OFF) && (msg.msg_status < SYSEX);
  assign in_omit    = (RUNNING_STATUS != 0) && in_channel && rs_valid_q &&
                      (rs_q == msg.msg_status);

  // The byte-load decision is folded into the accepting cycle and into the
  // cycle the previous stop bit ends, so the line never idles between bytes.
  // StLoad is only occupied by a message that yields no bytes at all.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    last_idx_d = last_idx_q;
    uart_start = 1'b0;
    uart_data  = 8'hFF;
    unique case (state_q)
      StIdle: begin
        if (msg.msg_valid) begin
          if (in_len == 2'd0) begin
            state_d = StLoad;
          end else begin
            state_d    = StSend;
            byte_idx_d = in_omit ? 2'd1 : 2'd0;
            last_idx_d = in_len - 2'd1;
            uart_start = 1'b1;
            uart_data  = pick_byte(byte_idx_d, msg.msg_status, msg.msg_data1, msg.msg_data2);
          end
        end
      end
      StLoad: state_d = StIdle;
      StSend: begin
        if (uart_done) begin
          if (byte_idx_q == last_idx_q) begin
            state_d    = StIdle;
            byte_idx_d = 2'd0;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            uart_start = 1'b1;
            uart_data  = pick_byte(byte_idx_d, status_q, data1_q, data2_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_idx_q <= '0;
      last_idx_q <= '0;
      status_q   <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      rs_q       <= '0;
      rs_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      last_idx_q <= last_idx_d;
      if (accept) begin
        status_q <= msg.msg_status;
        data1_q  <= msg.msg_data1;
        data2_q  <= msg.msg_data2;
        if (in_channel) begin
          rs_q       <= msg.msg_status;
          rs_valid_q <= 1'b1;
        end else if (msg.msg_status[7] && (msg.msg_status < TIMING_CLOCK)) begin
          // System common cancels running status; realtime leaves it alone.
          rs_valid_q <= 1'b0;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (ClksPerBit)
  ) u_uart (
    .clk   (clk),
    .reset (reset),
    .start (uart_start),
    .data  (uart_data),
    .tx    (serial_tx),
    .done  (uart_done)
  );

endmodule

// File: tb/tb_midi_msg_tx.sv
module tb_midi_msg_tx;

  localparam int unsigned ClkFreq = 125000;
  localparam int unsigned Baud    = 31250;
  localparam int Cpb = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset0, reset1;
  logic tx0, tx1, busy0, busy1;

  midi_msg_tx_if m0 ();
  midi_msg_tx_if m1 ();

  midi_msg_tx #(.CLK_FREQ(ClkFreq), .BAUD(Baud), .RUNNING_STATUS(1)) dut0 (
    .clk(clk), .reset(reset0), .msg(m0), .serial_tx(tx0), .busy(busy0)
  );

  midi_msg_tx #(.CLK_FREQ(ClkFreq), .BAUD(Baud), .RUNNING_STATUS(0)) dut1 (
    .clk(clk), .reset(reset1), .msg(m1), .serial_tx(tx1), .busy(busy1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] rs0_m;
  bit rs0_v;
  bit mon_go = 0;
  int acc0 = 0;

  always @(posedge clk) if (!reset0 && m0.msg_valid === 1'b1 && m0.msg_ready === 1'b1) acc0++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: byte count straight from the status ranges.
  function automatic int model_len(input logic [7:0] s);
    if (s < 8'h80) return 0;
    if (s < 8'hC0) return 3;
    if (s < 8'hE0) return 2;
    if (s < 8'hF0) return 3;
    if (s == 8'hF1 || s == 8'hF3) return 2;
    if (s == 8'hF2) return 3;
    return 1;
  endfunction

  task automatic model_push(input int which, input logic [7:0] s, input logic [6:0] d1,
                            input logic [6:0] d2, output int nb);
    logic [7:0] b[3];
    int n;
    int first;
    b[0] = s;
    b[1] = {1'b0, d1};
    b[2] = {1'b0, d2};
    n = model_len(s);
    first = 0;
    if (which == 0 && n > 0) begin
      if (s >= 8'h80 && s < 8'hF0) begin
        if (rs0_v && rs0_m == s) first = 1;
        rs0_m = s;
        rs0_v = 1;
      end else if (s < 8'hF8) begin
        rs0_v = 0;
      end
    end
    nb = (n > 0) ? n - first : 0;
    for (int i = first; i < n; i++) begin
      if (which == 0) exp0.push_back(b[i]);
      else exp1.push_back(b[i]);
    end
  endtask

  function automatic logic get_tx(input int which);
    return (which == 0) ? tx0 : tx1;
  endfunction

  function automatic logic get_rst(input int which);
    return (which == 0) ? reset0 : reset1;
  endfunction

  function automatic logic get_rdy(input int which);
    return (which == 0) ? m0.msg_ready : m1.msg_ready;
  endfunction

  task automatic set_in(input int which, input logic v, input logic [7:0] s,
                        input logic [6:0] d1, input logic [6:0] d2);
    if (which == 0) begin
      m0.msg_valid = v; m0.msg_status = s; m0.msg_data1 = d1; m0.msg_data2 = d2;
    end else begin
      m1.msg_valid = v; m1.msg_status = s; m1.msg_data1 = d1; m1.msg_data2 = d2;
    end
  endtask

  task automatic drop_valid(input int which);
    if (which == 0) m0.msg_valid = 1'b0;
    else m1.msg_valid = 1'b0;
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input int which, input logic [7:0] s, input logic [6:0] d1,
                      input logic [6:0] d2, input bit hold, output int nb);
    bit rdy;
    bit done;
    done = 0;
    model_push(which, s, d1, d2, nb);
    set_in(which, 1'b1, s, d1, d2);
    for (int t = 0; t < 4000 && !done; t++) begin
      rdy = (get_rdy(which) === 1'b1);
      @(posedge clk);
      #1;
      done = rdy;
    end
    if (!hold) drop_valid(which);
    if (!done) check("accept_timeout", 0, 1);
  endtask

  // k = cycle (1 = first after acceptance) at which ready is seen high.
  task automatic wait_idle(input int which, output int k);
    k = 1;
    while (get_rdy(which) !== 1'b1 && k < 4000) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  function automatic int exp_k(input int nb);
    return (nb == 0) ? 2 : nb * 10 * Cpb + 1;
  endfunction

  task automatic send_check(input int which, input string name, input logic [7:0] s,
                            input logic [6:0] d1, input logic [6:0] d2);
    int nb;
    int k;
    send(which, s, d1, d2, 0, nb);
    wait_idle(which, k);
    check(name, k, exp_k(nb));
  endtask

  // UART monitor: sees the start bit at its first cycle, then samples bit centres.
  task automatic uart_mon(input int which);
    logic [7:0] b;
    bit ok;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (get_rst(which) !== 1'b0 || get_tx(which) !== 1'b0) continue;
      ok = 1;
      b = '0;
      for (int i = 0; i < 10 && ok; i++) begin
        for (int c = 0; c < ((i == 0) ? 2 : Cpb); c++) begin
          @(negedge clk);
          if (get_rst(which) !== 1'b0) begin
            ok = 0;
            break;
          end
        end
        if (ok) begin
          if (i == 0) check("start_bit", get_tx(which), 0);
          else if (i < 9) b[i-1] = get_tx(which);
          else check("stop_bit", get_tx(which), 1);
        end
      end
      if (ok) begin
        if (which == 0 ? exp0.size() == 0 : exp1.size() == 0) begin
          check("unexpected_byte", b, 32'hFFFF_FFFF);
        end else begin
          e = (which == 0) ? exp0.pop_front() : exp1.pop_front();
          check((which == 0) ? "byte_rs1" : "byte_rs0", b, e);
        end
      end
    end
  endtask

  initial begin wait (mon_go); uart_mon(0); end
  initial begin wait (mon_go); uart_mon(1); end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic rand_run(input int which, input int n);
    logic [7:0] s;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: s = 8'h90;
        3:       s = 8'hC2;
        4:       s = 8'hF8;
        5:       s = 8'($urandom_range(0, 127));
        default: s = 8'($urandom_range(128, 255));
      endcase
      send_check(which, "rand_len", s, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int nb;
    int k;
    int a0;
    reset0 = 1'b1;
    reset1 = 1'b1;
    set_in(0, 1'b0, 8'h00, 7'h00, 7'h00);
    set_in(1, 1'b0, 8'h00, 7'h00, 7'h00);
    repeat (3) @(posedge clk);
    #1;
    reset0 = 1'b0;
    reset1 = 1'b0;
    check("reset_tx", tx0, 1);
    check("reset_ready", m0.msg_ready, 1);
    check("reset_busy", busy0, 0);
    mon_go = 1;
    @(posedge clk);
    #1;

    // Note-on after reset: full three bytes, start bit the cycle after accept.
    send(0, 8'h90, 7'h3C, 7'h64, 0, nb);
    check("start_after_accept", tx0, 0);
    check("busy_after_accept", busy0, 1);
    wait_idle(0, k);
    check("note_on_len", k, 121);

    send_check(0, "running_status", 8'h90, 7'h3E, 7'h40);
    send_check(0, "realtime", 8'hF8, 7'h00, 7'h00);
    send_check(0, "rs_after_rt", 8'h90, 7'h3C, 7'h00);
    send_check(0, "song_pos", 8'hF2, 7'h00, 7'h01);
    send_check(0, "rs_resend", 8'h90, 7'h3C, 7'h64);
    send_check(0, "prog_change", 8'hC5, 7'h07, 7'h00);
    send_check(0, "data_7f", 8'hC5, 7'h7F, 7'h00);

    // Non-status byte: ready low for exactly one cycle, line stays idle.
    send(0, 8'h3C, 7'h11, 7'h22, 0, nb);
    check("invalid_ready_low", m0.msg_ready, 0);
    check("invalid_tx_idle", tx0, 1);
    @(posedge clk);
    #1;
    check("invalid_ready_back", m0.msg_ready, 1);

    // Held valid through busy: one acceptance only.
    a0 = acc0;
    send(0, 8'hE0, 7'h12, 7'h34, 1, nb);
    wait_idle(0, k);
    drop_valid(0);
    check("held_valid_len", k, exp_k(nb));
    check("held_valid_accepts", acc0 - a0, 1);

    // Reset in a data bit of byte 2.
    send(0, 8'h90, 7'h3C, 7'h64, 0, nb);
    repeat (54) @(posedge clk);
    #1;
    reset0 = 1'b1;
    exp0.delete();
    rs0_v = 0;
    @(posedge clk);
    #1;
    check("abort_tx", tx0, 1);
    check("abort_ready", m0.msg_ready, 1);
    check("abort_busy", busy0, 0);
    reset0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_check(0, "post_abort_status", 8'h90, 7'h01, 7'h02);

    // Running status disabled: status always sent.
    send_check(1, "no_rs_first", 8'h90, 7'h3C, 7'h64);
    send_check(1, "no_rs_repeat", 8'h90, 7'h3E, 7'h40);

    fork
      rand_run(0, 25);
      rand_run(1, 25);
    join

    repeat (50) @(posedge clk);
    #1;
    check("drain_rs1", exp0.size(), 0);
    check("drain_rs0", exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
